mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Data-memory bus controller directly downstream of the MEM pipeline stage.
- Consumes the stage's request outputs (dreq, dwrite, daddr, dsize, store data) and runs the handshake with the data cache/bus (ready_n, busy).
- Steers store bytes onto the correct lanes, and extracts/extends load data.
- Generates the pipeline `keep` stall so the MEM/WB register holds until the access completes.

Parameters:
- TIMEOUT_W, 8, width of the wait-for-ready watchdog counter.
- TIMEOUT, 8'd255, cycles in WAIT without ready before the access is aborted with error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- dreq  in  1  access request from the MEM stage.
- dwrite  in  1  1 = store, 0 = load.
- daddr  in  32  byte address.
- dsize  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- ld_unsigned  in  1  1 = zero-extend the load (LBU/LHU), 0 = sign-extend.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  load result, aligned and extended, registered.
- keep  out  1  pipeline stall request.
- err_misalign  out  1  one-cycle pulse on a misaligned access.
- err_timeout  out  1  one-cycle pulse on watchdog expiry.
- bus_req  out  1  bus request.
- bus_write  out  1  bus write enable.
- bus_addr  out  32  word address, {daddr[31:2], 2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-steered store data.
- bus_rdata  in  32  bus read data.
- bus_ready_n  in  1  active-low data-ready.
- bus_busy  in  1  bus cannot accept a request this cycle.

Behaviour:
- Reset (rst=1 at posedge):
  - state = IDLE.
  - rdata = 0, keep = 0, err_* = 0, bus_req = 0, bus_write = 0, bus_be = 0, bus_addr = 0, bus_wdata = 0, watchdog = 0.
  - Reset mid-access abandons the access: bus_req is low on the cycle after reset, and nothing is retried.
- States: IDLE, ISSUE, WAIT, DONE.
- keep (combinational) = (state==IDLE & dreq) | state==ISSUE | state==WAIT. keep is 0 in DONE.
- IDLE:
  - dreq=0: stay in IDLE.
  - dreq=1 and aligned: latch addr, size, ld_unsigned, write, steered data and byte enables; go to ISSUE.
  - dreq=1 and misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to DONE, pulse err_misalign in DONE, set rdata=0, issue no bus access.
- ISSUE:
  - bus_req=1, with bus_write/addr/be/wdata driven from the latched values.
  - bus_busy=1: stay in ISSUE.
  - bus_busy=0: go to WAIT and clear the watchdog.
- WAIT:
  - bus_req is held at 1; bus outputs are held stable.
  - bus_ready_n=0: for a load, capture the extracted/extended bus_rdata into rdata; for a store, leave rdata unchanged. Go to DONE.
  - Otherwise increment the watchdog. When watchdog==TIMEOUT, go to DONE with err_timeout pulsed in DONE and rdata=0 for a load.
  - When ready and the watchdog limit coincide, ready wins: normal completion, no error.
- DONE:
  - bus_req=0; go to IDLE unconditionally.
  - The pipeline advances on this edge. A new dreq is seen in IDLE on the following cycle, which gives back-to-back accesses with no lost request.
- Latency: with busy=0 and ready in the first WAIT cycle, keep is high for 3 cycles (IDLE, ISSUE, WAIT), and rdata is valid from DONE onward.
- rdata holds its value until the next load completes, a fault occurs, or reset.
- Byte enables: byte → 4'b0001 << addr[1:0]; half → 4'b0011 << {addr[1],1'b0}; word → 4'b1111.
- Store data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Load extraction: select byte lane addr[1:0] or half lane addr[1] from bus_rdata, then zero-extend or sign-extend according to ld_unsigned. A word load passes through unchanged.

Decomposition:
- define.v gains the following constants:
  - DSIZE_B = 2'b00, DSIZE_H = 2'b01, DSIZE_W = 2'b10.
  - MBC_IDLE/ISSUE/WAIT/DONE state encodings (2-bit).
- One combinational sub-module, mem_lane_align:
  - Inputs: addr[1:0], size, ld_unsigned, wdata, bus_rdata.
  - Outputs: be, steered wdata, extracted rdata, misalign flag.
- The FSM, watchdog and registers remain in mem_bus_ctrl.

Test Plan:
- Word load, addr 0x100, busy=0, ready_n=0 on the first WAIT cycle, bus_rdata=0xDEADBEEF → bus_be=4'hF, bus_addr=0x100, keep high for exactly 3 cycles, rdata=0xDEADBEEF in DONE.
- Byte load, addr 0x103, signed, bus_rdata=0x80FF_0000 → bus_be=4'b1000, rdata=0xFFFFFF80. Repeat with ld_unsigned=1 → rdata=0x00000080.
- Half store, addr 0x202, wdata=0x0000_1234, bus_busy=1 for 2 cycles → bus_req stays high through ISSUE, bus_be=4'b1100, bus_wdata=0x12341234, bus_addr=0x200, rdata unchanged.
- Word load, addr 0x101 → no bus_req ever, err_misalign pulses once, keep drops after 1 cycle, rdata=0.
- Load with ready_n held at 1 → after 255 WAIT cycles err_timeout pulses, rdata=0, FSM returns to IDLE. A variant with ready arriving on cycle 255 → normal completion, no error.
- rst asserted during WAIT → next cycle bus_req=0, keep=0, state IDLE. A subsequent word load completes normally.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared encodings for the data-memory bus controller: access sizes and FSM states.
package mem_bus_ctrl_pkg;

    localparam logic [1:0] DSIZE_B = 2'b00;
    localparam logic [1:0] DSIZE_H = 2'b01;
    localparam logic [1:0] DSIZE_W = 2'b10;

    typedef enum logic [1:0] {
        MBC_IDLE  = 2'b00,
        MBC_ISSUE = 2'b01,
        MBC_WAIT  = 2'b10,
        MBC_DONE  = 2'b11
    } mbc_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads, alignment check.
module mem_lane_align
    import mem_bus_ctrl_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_steered,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte       = bus_rdata[8*addr +: 8];
        rd_half       = addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        be            = 4'b1111;
        wdata_steered = wdata;
        rdata_ext     = bus_rdata;
        misalign      = 1'b0;
        case (size)
            DSIZE_B: begin
                be            = 4'b0001 << addr;
                wdata_steered = {4{wdata[7:0]}};
                rdata_ext     = ld_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            DSIZE_H: begin
                be            = 4'b0011 << {addr[1], 1'b0};
                wdata_steered = {2{wdata[15:0]}};
                rdata_ext     = ld_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
                misalign      = addr[0];
            end
            // size 11 behaves as a word access
            default: begin
                misalign      = |addr;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Data-memory bus controller behind the MEM stage: handshake FSM, watchdog and pipeline stall.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int unsigned            TIMEOUT_W = 8,
    parameter logic [TIMEOUT_W-1:0]   TIMEOUT   = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dreq,
    input  logic        dwrite,
    input  logic [31:0] daddr,
    input  logic [1:0]  dsize,
    input  logic        ld_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        keep,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic        bus_req,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready_n,
    input  logic        bus_busy
);

    mbc_state_e           state_q, state_d;
    logic [1:0]           lat_lane, lat_size;
    logic                 lat_uns;
    logic [TIMEOUT_W-1:0] watchdog, wd_inc;

    logic [1:0]  al_addr, al_size;
    logic        al_uns;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;
    logic        al_mis;

    logic start_hit, mis_hit, ready_hit, to_hit, issue_go;

    // Live request drives the aligner in IDLE; afterwards the latched access does.
    assign al_addr = (state_q == MBC_IDLE) ? daddr[1:0]  : lat_lane;
    assign al_size = (state_q == MBC_IDLE) ? dsize       : lat_size;
    assign al_uns  = (state_q == MBC_IDLE) ? ld_unsigned : lat_uns;

    mem_lane_align u_align (
        .addr          (al_addr),
        .size          (al_size),
        .ld_unsigned   (al_uns),
        .wdata         (wdata),
        .bus_rdata     (bus_rdata),
        .be            (al_be),
        .wdata_steered (al_wdata),
        .rdata_ext     (al_rdata),
        .misalign      (al_mis)
    );

    assign wd_inc = watchdog + {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) state_q <= MBC_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MBC_IDLE:  if (dreq) state_d = al_mis ? MBC_DONE : MBC_ISSUE;
            MBC_ISSUE: if (!bus_busy) state_d = MBC_WAIT;
            MBC_WAIT:  if (!bus_ready_n || wd_inc == TIMEOUT) state_d = MBC_DONE;
            default:   state_d = MBC_IDLE;
        endcase
    end

    always_comb begin
        keep      = ((state_q == MBC_IDLE) && dreq) || (state_q == MBC_ISSUE) || (state_q == MBC_WAIT);
        bus_req   = (state_q == MBC_ISSUE) || (state_q == MBC_WAIT);
        start_hit = (state_q == MBC_IDLE) && dreq && !al_mis;
        mis_hit   = (state_q == MBC_IDLE) && dreq && al_mis;
        issue_go  = (state_q == MBC_ISSUE) && !bus_busy;
        ready_hit = (state_q == MBC_WAIT) && !bus_ready_n;
        to_hit    = (state_q == MBC_WAIT) && bus_ready_n && (wd_inc == TIMEOUT);
    end

    // Latched access, watchdog, load result and error pulses (each pulse lands in DONE)
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_lane     <= 2'b00;
            lat_size     <= DSIZE_B;
            lat_uns      <= 1'b0;
            bus_write    <= 1'b0;
            bus_addr     <= 32'h0;
            bus_be       <= 4'h0;
            bus_wdata    <= 32'h0;
            watchdog     <= '0;
            rdata        <= 32'h0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_misalign <= mis_hit;
            err_timeout  <= to_hit;
            if (start_hit) begin
                lat_lane  <= daddr[1:0];
                lat_size  <= dsize;
                lat_uns   <= ld_unsigned;
                bus_write <= dwrite;
                bus_addr  <= {daddr[31:2], 2'b00};
                bus_be    <= al_be;
                bus_wdata <= al_wdata;
            end
            if (issue_go) watchdog <= '0;
            else if ((state_q == MBC_WAIT) && bus_ready_n) watchdog <= wd_inc;
            if (mis_hit) rdata <= 32'h0;
            else if (ready_hit && !bus_write) rdata <= al_rdata;
            else if (to_hit && !bus_write) rdata <= 32'h0;
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed-vector bench for mem_bus_ctrl with hand-computed expectations.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dreq, dwrite, ld_unsigned;
    logic [31:0] daddr, wdata, bus_rdata;
    logic [1:0]  dsize;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic        keep, err_misalign, err_timeout, bus_req, bus_write;
    logic [3:0]  bus_be;
    logic        bus_ready_n, bus_busy;

    always #5 clk = ~clk;

    mem_bus_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .dreq         (dreq),
        .dwrite       (dwrite),
        .daddr        (daddr),
        .dsize        (dsize),
        .ld_unsigned  (ld_unsigned),
        .wdata        (wdata),
        .rdata        (rdata),
        .keep         (keep),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout),
        .bus_req      (bus_req),
        .bus_write    (bus_write),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ready_n  (bus_ready_n),
        .bus_busy     (bus_busy)
    );

    int vec_cnt    = 0;
    int miscmp_cnt = 0;

    int          r_keep, r_req, r_mis, r_to;
    logic [3:0]  r_be;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic        r_write, r_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access: busy for busy_n request cycles, ready on WAIT cycle wait_n (0 = never).
    task automatic xact(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd, input logic [31:0] rd,
                        input int busy_n, input int wait_n);
        r_keep = 0; r_req = 0; r_mis = 0; r_to = 0; r_done = 1'b0;
        r_be = 4'h0; r_addr = 32'h0; r_wdata = 32'h0; r_write = 1'b0; r_rdata = 32'hx;
        @(negedge clk);
        dreq = 1'b1; dwrite = wr; daddr = addr; dsize = sz; ld_unsigned = uns;
        wdata = wd; bus_rdata = rd;
        for (int c = 0; c < 1000 && !r_done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                dreq = 1'b0;
            end
            if (bus_req) begin
                bus_busy    = (r_req < busy_n);
                bus_ready_n = !(wait_n > 0 && r_req == busy_n + wait_n);
            end else begin
                bus_busy    = 1'b0;
                bus_ready_n = 1'b1;
            end
            #1;
            if (bus_req) begin
                r_req++;
                r_be = bus_be; r_addr = bus_addr; r_wdata = bus_wdata; r_write = bus_write;
            end
            if (err_misalign) r_mis++;
            if (err_timeout)  r_to++;
            if (keep) r_keep++;
            else begin
                r_done  = 1'b1;
                r_rdata = rdata;
            end
        end
        chk("xact_completes", {31'b0, r_done}, 32'd1);
        @(negedge clk);
        bus_ready_n = 1'b1;
        #1;
        if (err_misalign) r_mis++;
        if (err_timeout)  r_to++;
        if (bus_req)      r_req++;
    endtask

    initial begin
        rst = 1'b1; dreq = 1'b0; dwrite = 1'b0; daddr = 32'h0; dsize = 2'b00;
        ld_unsigned = 1'b0; wdata = 32'h0; bus_rdata = 32'h0;
        bus_ready_n = 1'b1; bus_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_keep", {31'b0, keep}, 32'd0);
        chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst_bus_write", {31'b0, bus_write}, 32'd0);
        chk("rst_bus_be", {28'b0, bus_be}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_errs", {30'b0, err_misalign, err_timeout}, 32'h0);

        xact(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 0, 1);
        chk("wld_keep_cycles", r_keep, 3);
        chk("wld_req_cycles", r_req, 2);
        chk("wld_be", {28'b0, r_be}, 32'hF);
        chk("wld_addr", r_addr, 32'h100);
        chk("wld_write", {31'b0, r_write}, 32'd0);
        chk("wld_rdata", r_rdata, 32'hDEADBEEF);
        chk("wld_errs", r_mis + r_to, 0);

        xact(1'b0, 32'h103, 2'b00, 1'b0, 32'h0, 32'h80FF_0000, 0, 1);
        chk("lb_be", {28'b0, r_be}, 32'h8);
        chk("lb_addr", r_addr, 32'h100);
        chk("lb_rdata", r_rdata, 32'hFFFFFF80);

        xact(1'b0, 32'h103, 2'b00, 1'b1, 32'h0, 32'h80FF_0000, 0, 1);
        chk("lbu_rdata", r_rdata, 32'h00000080);

        xact(1'b1, 32'h202, 2'b01, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF, 2, 1);
        chk("sh_keep_cycles", r_keep, 5);
        chk("sh_req_cycles", r_req, 4);
        chk("sh_be", {28'b0, r_be}, 32'hC);
        chk("sh_wdata", r_wdata, 32'h12341234);
        chk("sh_addr", r_addr, 32'h200);
        chk("sh_write", {31'b0, r_write}, 32'd1);
        chk("sh_rdata_held", r_rdata, 32'h00000080);

        xact(1'b0, 32'h101, 2'b10, 1'b0, 32'h0, 32'h5555_5555, 0, 1);
        chk("mis_keep_cycles", r_keep, 1);
        chk("mis_req_cycles", r_req, 0);
        chk("mis_pulses", r_mis, 1);
        chk("mis_rdata", r_rdata, 32'h0);

        xact(1'b0, 32'h301, 2'b01, 1'b1, 32'h0, 32'h5555_5555, 0, 1);
        chk("mis_half_pulses", r_mis, 1);
        chk("mis_half_req", r_req, 0);

        xact(1'b0, 32'h300, 2'b10, 1'b0, 32'h0, 32'h12345678, 0, 255);
        chk("rdy255_keep_cycles", r_keep, 257);
        chk("rdy255_to_pulses", r_to, 0);
        chk("rdy255_rdata", r_rdata, 32'h12345678);

        xact(1'b0, 32'h300, 2'b10, 1'b0, 32'h0, 32'h12345678, 0, 0);
        chk("to_keep_cycles", r_keep, 257);
        chk("to_req_cycles", r_req, 256);
        chk("to_pulses", r_to, 1);
        chk("to_rdata", r_rdata, 32'h0);

        @(negedge clk);
        dreq = 1'b1; dwrite = 1'b0; daddr = 32'h108; dsize = 2'b10; ld_unsigned = 1'b0;
        bus_busy = 1'b0; bus_ready_n = 1'b1; bus_rdata = 32'hAAAA_AAAA;
        @(negedge clk);
        dreq = 1'b0;
        @(negedge clk);
        #1;
        chk("rstmid_in_wait_req", {31'b0, bus_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_ready_n = 1'b0;
        #1;
        chk("rstmid_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rstmid_keep", {31'b0, keep}, 32'd0);
        chk("rstmid_bus_addr", bus_addr, 32'h0);
        @(negedge clk);
        #1;
        chk("rstmid_no_retry", {31'b0, bus_req}, 32'd0);
        chk("rstmid_rdata", rdata, 32'h0);
        bus_ready_n = 1'b1;

        xact(1'b0, 32'h104, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 0, 1);
        chk("post_rst_keep_cycles", r_keep, 3);
        chk("post_rst_addr", r_addr, 32'h104);
        chk("post_rst_rdata", r_rdata, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
